// File: rtl/load_store_unit_if.sv
// Bus bundle between the load/store unit and its memory slave.
// The slave returns load data right-aligned to addr and stores bytes from addr upward.
interface WISHBONE_IF;
   logic [31:0] addr;
   logic [31:0] data_write;
   logic [31:0] data_read;
   logic [1:0]  width;
   logic        we;
   logic        stb;
   logic        cyc;
   logic        ack;

   modport master (output addr, data_write, width, we, stb, cyc, input data_read, ack);
   modport slave  (input addr, data_write, width, we, stb, cyc, output data_read, ack);
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: checks alignment and funct3, runs one bus
// access with a timeout, then reports one valid or fault pulse.
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iReq,
   input  logic        iWe,
   input  logic [2:0]  iFunct3,
   input  logic [31:0] iAddr,
   input  logic [31:0] iData,
   output logic        oBusy,
   output logic        oValid,
   output logic [31:0] oData,
   output logic        oFault,
   WISHBONE_IF.master  mem_wb
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_r;
   logic [2:0]  funct3_r;
   logic [7:0]  tmo_cnt_r;
   logic        req_fault_s;
   logic [1:0]  width_s;

   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      case (f3)
         3'b000:  r = {{24{d[7]}}, d[7:0]};
         3'b001:  r = {{16{d[15]}}, d[15:0]};
         3'b100:  r = {24'h000000, d[7:0]};
         3'b101:  r = {16'h0000, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   // Request legality and bus width decode; unsigned loads have no store form.
   always_comb begin
      req_fault_s = 1'b1;
      width_s     = 2'b00;
      case (iFunct3)
         3'b000: begin width_s = 2'b00; req_fault_s = 1'b0;                   end
         3'b001: begin width_s = 2'b01; req_fault_s = iAddr[0];               end
         3'b010: begin width_s = 2'b10; req_fault_s = |iAddr[1:0];            end
         3'b100: begin width_s = 2'b00; req_fault_s = iWe;                    end
         3'b101: begin width_s = 2'b01; req_fault_s = iWe | iAddr[0];         end
         default: begin width_s = 2'b00; req_fault_s = 1'b1;                  end
      endcase
   end

   // Control FSM with registered CPU outputs and bus fields.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_r           <= IDLE;
         funct3_r          <= 3'b000;
         tmo_cnt_r         <= 8'd0;
         oBusy             <= 1'b0;
         oValid            <= 1'b0;
         oFault            <= 1'b0;
         oData             <= 32'h0000_0000;
         mem_wb.cyc        <= 1'b0;
         mem_wb.stb        <= 1'b0;
         mem_wb.we         <= 1'b0;
         mem_wb.addr       <= 32'h0000_0000;
         mem_wb.data_write <= 32'h0000_0000;
         mem_wb.width      <= 2'b00;
      end else begin
         oValid <= 1'b0;
         oFault <= 1'b0;
         oData  <= 32'h0000_0000;
         case (state_r)
            IDLE: begin
               if (iReq) begin
                  oBusy <= 1'b1;
                  if (req_fault_s) begin
                     state_r <= RESP;
                     oFault  <= 1'b1;
                  end else begin
                     state_r           <= BUS;
                     funct3_r          <= iFunct3;
                     tmo_cnt_r         <= 8'd0;
                     mem_wb.addr       <= iAddr;
                     mem_wb.we         <= iWe;
                     mem_wb.data_write <= iData;
                     mem_wb.width      <= width_s;
                     mem_wb.cyc        <= 1'b1;
                     mem_wb.stb        <= 1'b1;
                  end
               end else begin
                  oBusy <= 1'b0;
               end
            end
            BUS: begin
               // ack on the final timeout edge still completes normally
               if (mem_wb.ack) begin
                  state_r    <= RESP;
                  mem_wb.cyc <= 1'b0;
                  mem_wb.stb <= 1'b0;
                  oValid     <= 1'b1;
                  oData      <= mem_wb.we ? 32'h0000_0000 : extend_load(funct3_r, mem_wb.data_read);
               end else if (tmo_cnt_r == TMO_LAST) begin
                  state_r    <= RESP;
                  mem_wb.cyc <= 1'b0;
                  mem_wb.stb <= 1'b0;
                  oFault     <= 1'b1;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + 8'd1;
               end
            end
            RESP: begin
               state_r <= IDLE;
               oBusy   <= 1'b0;
            end
            default: begin
               state_r    <= IDLE;
               oBusy      <= 1'b0;
               mem_wb.cyc <= 1'b0;
               mem_wb.stb <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

   localparam int TMO = 16;

   logic        iClk;
   logic        iRst;
   logic        iReq;
   logic        iWe;
   logic [2:0]  iFunct3;
   logic [31:0] iAddr;
   logic [31:0] iData;
   logic        oBusy;
   logic        oValid;
   logic [31:0] oData;
   logic        oFault;

   WISHBONE_IF wb ();

   load_store_unit #(.TIMEOUT(TMO)) dut (
      .iClk    (iClk),
      .iRst    (iRst),
      .iReq    (iReq),
      .iWe     (iWe),
      .iFunct3 (iFunct3),
      .iAddr   (iAddr),
      .iData   (iData),
      .oBusy   (oBusy),
      .oValid  (oValid),
      .oData   (oData),
      .oFault  (oFault),
      .mem_wb  (wb)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // bus slave memory
   logic [7:0]  mem [0:255];
   logic        mem_clr;
   int          ack_lat;
   int          wait_cnt;
   int          ack_count;

   always_comb begin
      wb.ack       = wb.cyc && wb.stb && (wait_cnt >= ack_lat);
      wb.data_read = {mem[wb.addr[7:0] + 8'd3], mem[wb.addr[7:0] + 8'd2],
                      mem[wb.addr[7:0] + 8'd1], mem[wb.addr[7:0]]};
   end

   always @(posedge iClk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         wait_cnt  <= 0;
         ack_count <= 0;
      end else begin
         if (wb.cyc && wb.stb && wb.ack && wb.we) begin
            mem[wb.addr[7:0]] <= wb.data_write[7:0];
            if (wb.width != 2'b00) mem[wb.addr[7:0] + 8'd1] <= wb.data_write[15:8];
            if (wb.width == 2'b10) begin
               mem[wb.addr[7:0] + 8'd2] <= wb.data_write[23:16];
               mem[wb.addr[7:0] + 8'd3] <= wb.data_write[31:24];
            end
         end
         if (!wb.cyc || wb.ack) wait_cnt <= 0;
         else                   wait_cnt <= wait_cnt + 1;
         if (wb.cyc && wb.stb && wb.ack) ack_count <= ack_count + 1;
      end
   end

   // reference model: plain byte array and access rules
   int unsigned ref_mem [0:255];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_odata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      if (f3 % 4 == 0)      return 1;
      else if (f3 % 4 == 1) return 2;
      else                  return 4;
   endfunction

   function automatic bit model_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'd0:    return 1'b0;
         3'd1:    return (a % 2) != 0;
         3'd2:    return (a % 4) != 0;
         3'd4:    return we;
         3'd5:    return we || ((a % 2) != 0);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] v = 32'd0;
      for (int i = 0; i < nbytes(f3); i++)
         v = v + (ref_mem[(a + 32'(i)) % 256] << (8 * i));
      if (f3 == 3'd0 && v >= 32'd128)   v = v - 32'd256;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      return v;
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      for (int i = 0; i < nbytes(f3); i++)
         ref_mem[(a + 32'(i)) % 256] = (d >> (8 * i)) % 256;
   endtask

   // one request issued at a negedge; returns at the negedge after the idle check
   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input int lat);
      bit          exp_fault, tmo, got_v, got_f, bus_bad;
      int          exp_k, exp_cyc, k, cyc_n, nb;
      logic [31:0] exp_data, got_data;
      logic [1:0]  exp_w;
      exp_fault = model_fault(we, f3, a);
      tmo       = !exp_fault && (lat >= TMO);
      nb        = nbytes(f3);
      exp_w     = (nb == 1) ? 2'b00 : (nb == 2) ? 2'b01 : 2'b10;
      exp_data  = (exp_fault || tmo || we) ? 32'd0 : model_load(f3, a);
      exp_k     = exp_fault ? 1 : tmo ? TMO + 1 : lat + 2;
      exp_cyc   = exp_fault ? 0 : tmo ? TMO : lat + 1;
      if (!exp_fault && !tmo && we) model_store(f3, a, d);
      ack_lat = lat;
      iReq = 1'b1; iWe = we; iFunct3 = f3; iAddr = a; iData = d;
      @(posedge iClk);
      k = 0; cyc_n = 0; bus_bad = 1'b0; got_v = 1'b0; got_f = 1'b0; got_data = 32'd0;
      for (int i = 1; i <= 40 && k == 0; i++) begin
         @(negedge iClk);
         if (i == 1) begin
            iReq = 1'b0;
            chk("busy_after_req", 32'(oBusy), 32'd1);
         end
         if (wb.cyc) begin
            cyc_n++;
            if (wb.stb !== 1'b1 || wb.addr !== a || wb.we !== we ||
                wb.width !== exp_w || wb.data_write !== d) bus_bad = 1'b1;
         end
         if (oValid || oFault) begin
            k = i; got_v = oValid; got_f = oFault; got_data = oData;
         end else if (oData !== 32'd0) begin
            bus_bad = 1'b1;
         end
      end
      chk("latency", 32'(k), 32'(exp_k));
      chk("cyc_cycles", 32'(cyc_n), 32'(exp_cyc));
      chk("bus_fields", 32'(bus_bad), 32'd0);
      chk("valid", 32'(got_v), 32'(!(exp_fault || tmo)));
      chk("fault", 32'(got_f), 32'(exp_fault || tmo));
      chk("odata", got_data, exp_data);
      @(negedge iClk);
      chk("idle_after", {28'd0, oBusy, oValid, oFault, wb.cyc}, 32'd0);
      chk("idle_odata", oData, 32'd0);
      last_odata = got_data;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k, bad, n0;
      logic        got_v;
      logic [31:0] got_d, exp_d, a;
      iRst = 1'b0; iReq = 1'b0; iWe = 1'b0; iFunct3 = 3'd0; iAddr = 32'd0; iData = 32'd0;
      mem_clr = 1'b1; ack_lat = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 0;
      repeat (3) @(negedge iClk);
      chk("rst_flags", {29'd0, oBusy, oValid, oFault}, 32'd0);
      chk("rst_odata", oData, 32'd0);
      chk("rst_bus", {27'd0, wb.cyc, wb.stb, wb.we, wb.width}, 32'd0);
      chk("rst_addr", wb.addr, 32'd0);
      chk("rst_wdata", wb.data_write, 32'd0);
      mem_clr = 1'b0;
      iRst = 1'b1;
      // first request on the first edge after release
      do_access(1'b1, 3'b010, 32'h10, 32'h80FF_7F01, 0);

      do_access(1'b0, 3'b010, 32'h10, 32'h0, 0); chk("lw_10", last_odata, 32'h80FF_7F01);
      do_access(1'b0, 3'b000, 32'h13, 32'h0, 1); chk("lb_13", last_odata, 32'hFFFF_FF80);
      do_access(1'b0, 3'b100, 32'h13, 32'h0, 0); chk("lbu_13", last_odata, 32'h0000_0080);
      do_access(1'b0, 3'b001, 32'h12, 32'h0, 2); chk("lh_12", last_odata, 32'hFFFF_80FF);
      do_access(1'b0, 3'b101, 32'h12, 32'h0, 0); chk("lhu_12", last_odata, 32'h0000_80FF);
      do_access(1'b1, 3'b000, 32'h21, 32'hAABB_CCDD, 1);
      do_access(1'b0, 3'b010, 32'h20, 32'h0, 2); chk("sb_readback", last_odata, 32'h0000_DD00);
      do_access(1'b0, 3'b010, 32'h22, 32'h0, 0);
      do_access(1'b1, 3'b001, 32'h05, 32'h1234, 0);
      do_access(1'b0, 3'b010, 32'h10, 32'h0, 1000);
      do_access(1'b0, 3'b010, 32'h10, 32'h0, 0); chk("lw_after_tmo", last_odata, 32'h80FF_7F01);

      // second request while busy and across RESP->IDLE is dropped
      ack_lat = 3; n0 = ack_count; exp_d = model_load(3'b010, 32'h10);
      iReq = 1'b1; iWe = 1'b0; iFunct3 = 3'b010; iAddr = 32'h10;
      @(posedge iClk);
      @(negedge iClk); iAddr = 32'h20;
      k = 0; got_v = 1'b0; got_d = 32'd0;
      for (int i = 2; i <= 20 && k == 0; i++) begin
         @(negedge iClk);
         if (oValid || oFault) begin k = i; got_v = oValid; got_d = oData; end
      end
      chk("ovl_latency", 32'(k), 32'd5);
      chk("ovl_valid", 32'(got_v), 32'd1);
      chk("ovl_data", got_d, exp_d);
      @(negedge iClk); iReq = 1'b0;
      chk("ovl_not_taken", 32'(oBusy), 32'd0);
      repeat (3) @(negedge iClk);
      chk("ovl_one_cycle", 32'(ack_count - n0), 32'd1);
      chk("ovl_idle", {30'd0, oBusy, wb.cyc}, 32'd0);

      // reset during a bus access
      ack_lat = 1000;
      iReq = 1'b1; iWe = 1'b0; iFunct3 = 3'b010; iAddr = 32'h10;
      @(posedge iClk);
      @(negedge iClk); iReq = 1'b0;
      @(negedge iClk);
      chk("mid_bus_cyc", 32'(wb.cyc), 32'd1);
      #2 iRst = 1'b0;
      #1 chk("async_drop", {29'd0, wb.cyc, wb.stb, oBusy}, 32'd0);
      repeat (2) @(negedge iClk);
      iRst = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge iClk);
         if (oValid || oFault || wb.cyc) bad++;
      end
      chk("post_reset_quiet", 32'(bad), 32'd0);

      for (int n = 0; n < 60; n++) begin
         a = 32'($urandom_range(0, 60));
         if ($urandom % 2 == 0) a = a - (a % 4);
         do_access(1'($urandom % 2), 3'($urandom_range(0, 7)), a, $urandom, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: number of BUS-state cycles without ack before the access is aborted (range 2..255).
REQ-002 SHALL have port iClk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port iRst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port iReq  input  1  CPU access request, sampled only in IDLE.
REQ-005 SHALL have port iWe  input  1  1 = store, 0 = load.
REQ-006 SHALL have port iFunct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port iAddr  input  32  byte address.
REQ-008 SHALL have port iData  input  32  store data, right-aligned.
REQ-009 SHALL have port oBusy  output  1  high while a request is outstanding (state != IDLE).
REQ-010 SHALL have port oValid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port oData  output  32  extended load result, valid when oValid=1; 0 otherwise.
REQ-012 SHALL have port oFault  output  1  one-cycle pulse for misaligned, illegal-funct3 or timeout; mutually exclusive with oValid.
REQ-013 SHALL have port mem_wb  WISHBONE_IF.master  --  bus master carrying addr[31:0], data_write[31:0], data_read[31:0], width[1:0], we, stb, cyc (driven) and ack (received).

Function
REQ-014 SHALL use the FSM states IDLE, BUS and RESP.
REQ-015 In IDLE with iReq=1 and a legal, aligned request, SHALL latch iAddr, iWe, iFunct3 and iData, and enter BUS.
REQ-016 SHALL treat H/HU with iAddr[0]=1, W with iAddr[1:0]!=0, or a funct3 outside the REQ-006 set (any funct3 other than 000/001/010 when iWe=1) as a fault.
  - On such a request SHALL enter RESP with the fault flag set.
  - SHALL issue no bus cycle for it.
REQ-017 SHALL set width as follows: B/BU = 00, H/HU = 01, W = 10.
REQ-018 SHALL drive data_write as the latched iData unshifted; the slave stores bytes from addr upward.
REQ-019 In BUS, SHALL hold cyc=stb=1 with addr, width, we and data_write stable from the latched values.
REQ-020 On an ack=1 edge in BUS, SHALL perform all of the following:
  - Capture data_read.
  - Extend the load result: B sign-extend bit 7, H sign-extend bit 15, BU/HU zero-extend, W unchanged.
  - Enter RESP.
  - Deassert cyc and stb from the next cycle.
REQ-021 SHALL reload the timeout counter to 0 on entry to BUS and increment it each BUS cycle without ack.
  - When the counter reaches TIMEOUT-1 with ack=0, SHALL enter RESP with the fault flag set.
  - ack on that same edge SHALL win: normal completion, no fault.
REQ-022 In RESP, SHALL assert exactly one of oValid or oFault for one cycle, then return to IDLE.
  - oData SHALL be 0 for stores and faults.
REQ-023 Latency: iReq at edge N means stb/cyc high in cycle N+1. With ack in cycle N+1, oValid is high in cycle N+2 and oBusy is low in cycle N+3. A fault request gives oFault in cycle N+1.
REQ-024 iReq while oBusy=1 SHALL be ignored and not queued; iReq in the RESP→IDLE cycle is not accepted.
REQ-025 SHALL register all outputs except the mem_wb fields, which are driven from state and latched registers only, with no combinational path from CPU inputs to mem_wb.

Reset
REQ-026 While iRst=0, SHALL immediately force state IDLE, cyc=stb=we=0, addr=data_write=0, width=00, oBusy=oValid=oFault=0, oData=0 and timeout counter=0.
REQ-027 Reset asserted mid-BUS SHALL drop cyc/stb asynchronously, abandon the access, and produce no oValid/oFault after release.
REQ-028 SHALL take the first request on the first rising edge after iRst deasserts.

Verification
REQ-029 LW: memory 0x10 = 0x80FF_7F01, iReq, iWe=0, funct3=010, addr=0x10 → width=10, stb/cyc for one cycle, oValid with oData=0x80FF_7F01 two cycles after request.
REQ-030 LB/LBU/LH/LHU at 0x13/0x13/0x12/0x12 on the same data → oData=0xFFFF_FF80, 0x0000_0080, 0xFFFF_80FF, 0x0000_80FF.
REQ-031 SB 0xAABB_CCDD to 0x21, then LW 0x20 (prior 0) → bus width=00, data_write=0xAABB_CCDD; readback 0x0000_DD00.
REQ-032 LW at 0x22 and SH at 0x05 → oFault one cycle after request each, cyc never asserted, oValid never asserted.
REQ-033 Slave never acks, TIMEOUT=16 → cyc high exactly 16 cycles, then oFault pulse, oBusy low next cycle; the next LW completes normally.
REQ-034 iRst pulsed low while cyc=1 → cyc/stb low the same timestep, no oValid/oFault after release; a second iReq during BUS is ignored (one bus cycle only).
